fsm_inv: RTL and testbench
==========================

FSM_INV -- requirements
Module: fsm_inv

Interface
REQ-001 Parameter WIDTH, default 32, operand width of recovered A and of input b.
REQ-002 Parameter OP_WIDTH, default WIDTH+3, width of encoded input y.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 y  input  OP_WIDTH  encoded value, y = (floor(A/2)+B)*8 + (A-floor(B/2))*4 mod 2^OP_WIDTH.
REQ-007 b  input  WIDTH  known operand B.
REQ-008 a  output  WIDTH  recovered operand A, registered.
REQ-009 err  output  1  y,b pair has no valid A, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 ready  output  1  one-cycle completion pulse; a and err valid while high and held until the next completion.

Function
REQ-012 The block SHALL invert the encoder: X = y - 8*b + 4*floor(b/2), and a = (X+4)>>3.
REQ-013 Internal datapath registers SHALL be OP_WIDTH+1 bits; all arithmetic is unsigned modulo 2^(OP_WIDTH+1); y and b are zero-extended on load.
REQ-014 Only shift-by-one and single add/sub per cycle are used; x8 = 3 cycles, x4 = 2 cycles, /8 = 3 cycles.
REQ-015 States and transitions, one edge each unless noted:
 - IDLE: start=1 -> latch y into rx, b into rb and rh; go B8. start=0 -> stay.
 - B8 (3 edges, counter 0..2): rb <= rb<<1; after third go BH.
 - BH: rh <= rh>>1; go BH4.
 - BH4 (2 edges): rh <= rh<<1; go SUB.
 - SUB: rx <= rx - rb; go ADD.
 - ADD: rx <= rx + rh; capture rx+rh bits [2:0] as lo3; go RND.
 - RND: rx <= rx + 4; go DIV.
 - DIV (3 edges): rx <= rx>>1; go CHK.
 - CHK: a <= rx[WIDTH-1:0]; err <= error condition; ready <= 1; go IDLE.
REQ-016 Latency: ready SHALL be high in the cycle following the 13th rising edge after the edge that sampled start=1 (sampling edge = edge 0).
REQ-017 ready SHALL be deasserted at the next edge after CHK regardless of start.
REQ-018 start while busy SHALL be ignored; start in IDLE during the ready cycle SHALL be accepted (back-to-back, 14-cycle throughput).
REQ-019 err SHALL be 1 iff any of: lo3 not in {000,100}; rx bits above WIDTH-1 nonzero at CHK; rx[0] != lo3[2] at CHK.
REQ-020 On err=1, a SHALL still be loaded with rx[WIDTH-1:0].
REQ-021 y and b changes after the sampling edge SHALL not affect the result.
REQ-022 Shift/step counter SHALL be cleared on every state exit.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, a=0, err=0, ready=0, busy=0, counter=0.
REQ-024 Reset mid-operation SHALL abort with no ready pulse; the first start after release restarts from IDLE.
REQ-025 Internal datapath registers need no reset value.

Verification
REQ-026 y=104, b=4, start 1 cycle -> ready at edge 13, a=10, err=0.
REQ-027 y=72, b=3 -> a=7, err=0; y=73, b=3 -> err=1 (lo3=101).
REQ-028 y=0, b=0 -> a=0, err=0; y=0, b=1 -> err=1 (A parity mismatch).
REQ-029 y=2^35-12, b=0 -> a=2^32-1, err=0; y=2^35-4, b=0 -> err=1, a=0 (overflow).
REQ-030 Start asserted at edge 5 of an operation -> ignored, single ready; start held in ready cycle -> second result 14 cycles later.
REQ-031 rst_n low at edge 7 -> outputs zero immediately, no ready; new start after release -> correct result at edge 13.

Source files
------------

// File: rtl/fsm_inv.sv
// Multi-cycle inverter for the (A,B) -> y encoder: recovers A from y and b
// using only shifts and one add/sub per cycle, and flags inputs with no valid A.
module fsm_inv #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = WIDTH + 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OP_WIDTH-1:0] y,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    a,
  output logic                err,
  output logic                busy,
  output logic                ready
);

  localparam int DW = OP_WIDTH + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_B8,
    S_BH,
    S_BH4,
    S_SUB,
    S_ADD,
    S_RND,
    S_DIV,
    S_CHK
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      cnt_q;
  logic [DW-1:0]   rx;
  logic [DW-1:0]   rb;
  logic [DW-1:0]   rh;
  logic [2:0]      lo3;
  logic [DW-1:0]   sum_xh;
  logic            chk_err;

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, matching the hardware they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: next state defaults to the current one so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_B8;
      S_B8:   if (cnt_q == 2'd2) state_d = S_BH;
      S_BH:   state_d = S_BH4;
      S_BH4:  if (cnt_q == 2'd1) state_d = S_SUB;
      S_SUB:  state_d = S_ADD;
      S_ADD:  state_d = S_RND;
      S_RND:  state_d = S_DIV;
      S_DIV:  if (cnt_q == 2'd2) state_d = S_CHK;
      S_CHK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Step counter for the multi-edge shift states; zeroed whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else if (state_d != state_q) begin
      cnt_q <= 2'd0;
    end else if (state_q == S_B8 || state_q == S_BH4 || state_q == S_DIV) begin
      cnt_q <= cnt_q + 2'd1;
    end else begin
      cnt_q <= 2'd0;
    end
  end

  assign sum_xh = rx + rh;

  // An odd or misaligned X, bits left above the operand, or a quotient whose
  // parity disagrees with the remainder all mean no A produces this y.
  assign chk_err = (lo3[1:0] != 2'b00)
                 | (|rx[DW-1:WIDTH])
                 | (rx[0] != lo3[2]);

  // NOTE: the datapath has no reset; it is always reloaded from y/b before use,
  // and only the control and result registers need a defined reset value.
  always_ff @(posedge clk) begin
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rx <= {{(DW-OP_WIDTH){1'b0}}, y};
          rb <= {{(DW-WIDTH){1'b0}}, b};
          rh <= {{(DW-WIDTH){1'b0}}, b};
        end
      end
      S_B8:  rb  <= rb << 1;
      S_BH:  rh  <= rh >> 1;
      S_BH4: rh  <= rh << 1;
      S_SUB: rx  <= rx - rb;
      S_ADD: begin
        rx  <= sum_xh;
        lo3 <= sum_xh[2:0];
      end
      S_RND: rx  <= rx + DW'(4);
      S_DIV: rx  <= rx >> 1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      err   <= 1'b0;
      ready <= 1'b0;
    end else begin
      ready <= (state_q == S_CHK);
      if (state_q == S_CHK) begin
        a   <= rx[WIDTH-1:0];
        err <= chk_err;
      end
    end
  end

endmodule

// File: tb/tb_fsm_inv.sv
// Scoreboard bench for fsm_inv: expected results queued at start, compared on ready.
module tb_fsm_inv;

  localparam int WIDTH    = 32;
  localparam int OP_WIDTH = WIDTH + 3;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic             err;
    longint           due;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [OP_WIDTH-1:0] y;
  logic [WIDTH-1:0]    b;
  logic [WIDTH-1:0]    a;
  logic                err;
  logic                busy;
  logic                ready;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  exp_t   sb[$];

  fsm_inv #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y     (y),
    .b     (b),
    .a     (a),
    .err   (err),
    .busy  (busy),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference inversion straight from the encoder algebra, in 36-bit modular arithmetic.
  function automatic exp_t model(input logic [OP_WIDTH-1:0] yv, input logic [WIDTH-1:0] bv);
    logic [OP_WIDTH:0] x;
    logic [OP_WIDTH:0] r;
    exp_t e;
    x = {1'b0, yv} - ({4'b0, bv} << 3) + ({4'b0, bv >> 1} << 2);
    r = (x + 36'd4) >> 3;
    e.a   = r[WIDTH-1:0];
    e.err = (x[1:0] != 2'b00) || (r[OP_WIDTH:WIDTH] != 0) || (r[0] != x[2]);
    e.due = 0;
    return e;
  endfunction

  function automatic logic [OP_WIDTH-1:0] encode(input longint av, input longint bv);
    longint v;
    v = ((av >>> 1) + bv) * 8 + (av - (bv >>> 1)) * 4;
    return OP_WIDTH'(v & ((64'sd1 <<< OP_WIDTH) - 1));
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 1, 0);
      end else begin
        e = sb.pop_front();
        check("a", a, e.a);
        check("err", err, e.err);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic do_op(input logic [OP_WIDTH-1:0] yv, input logic [WIDTH-1:0] bv,
                       input logic push_it, input logic [WIDTH-1:0] ea, input logic ee);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    y     = yv;
    b     = bv;
    if (push_it) begin
      e.a   = ea;
      e.err = ee;
      e.due = cyc + 14;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    y     = OP_WIDTH'($urandom);
    b     = $urandom;
    check("busy_run", busy, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    longint av, bv;
    logic [OP_WIDTH-1:0] yr;
    logic [WIDTH-1:0]    br;

    rst_n = 1'b0;
    start = 1'b0;
    y     = '0;
    b     = '0;
    #3;
    check("rst_a", a, 0);
    check("rst_err", err, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(35'd104, 32'd4, 1'b1, 32'd10, 1'b0);
    wait_drain();
    do_op(35'd72, 32'd3, 1'b1, 32'd7, 1'b0);
    wait_drain();
    do_op(35'd0, 32'd0, 1'b1, 32'd0, 1'b0);
    wait_drain();
    do_op(35'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    do_op(35'h7_FFFF_FFF4, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    do_op(35'h7_FFFF_FFFC, 32'd0, 1'b1, 32'd0, 1'b1);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      av = longint'($urandom_range(0, 65535));
      bv = longint'($urandom_range(0, 65535));
      do_op(encode(av, bv), WIDTH'(bv), 1'b1, WIDTH'(av), 1'b0);
      wait_drain();
    end

    for (int i = 0; i < 4; i++) begin
      yr = {$urandom_range(0, 7), $urandom};
      br = $urandom;
      e  = model(yr, br);
      do_op(yr, br, 1'b1, e.a, e.err);
      wait_drain();
    end

    // Start pulse in the middle of an operation must not restart it.
    do_op(35'd104, 32'd4, 1'b1, 32'd10, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    y     = 35'd0;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // Start held through the ready cycle launches a second operation.
    @(negedge clk);
    start = 1'b1;
    y     = 35'd104;
    b     = 32'd4;
    e.a = 32'd10; e.err = 1'b0; e.due = cyc + 14;
    sb.push_back(e);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    y = 35'd72;
    b = 32'd3;
    e.a = 32'd7; e.err = 1'b0; e.due = cyc + 14;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_b2b", busy, 1);
    wait_drain();
    repeat (5) @(negedge clk);

    // Leave a nonzero result with err set, then abort an operation with reset.
    do_op(35'd73, 32'd3, 1'b1, 32'd7, 1'b1);
    wait_drain();
    do_op(35'd72, 32'd3, 1'b0, 32'd0, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_a", a, 0);
    check("abort_err", err, 0);
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    do_op(35'd104, 32'd4, 1'b1, 32'd10, 1'b0);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
